uart_i2c_bridge: RTL and testbench

Command sequencer between the UART core's receive/transmit FIFOs and the I2C master controller. It replaces the button-driven single-byte path: the bridge pops framed commands from the UART RX FIFO and launches one I2C transaction per command via the master's `enable`/`ready` handshake. It then pushes a status or read-data byte back into the UART TX FIFO for the PC. It lets the host drive arbitrary I2C reads/writes to the second board without manual button presses.

---
 rtl/uart_i2c_pkg.sv | 21 ++
 rtl/uart_i2c_bridge.sv | 126 ++++++++++++
 tb/tb_uart_i2c_bridge.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_i2c_pkg.sv
// Shared types and constants for the UART-to-I2C command bridge.
package uart_i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_DATA,
    ST_START,
    ST_WAIT_BUSY,
    ST_WAIT_DONE,
    ST_RESP
  } state_t;

  localparam logic [7:0] ACK_BYTE_DEF = 8'h06;
  localparam logic [7:0] NAK_BYTE_DEF = 8'h15;

  // Header byte layout: {rw, addr[6:0]}
  localparam int HDR_RW_BIT   = 7;
  localparam int HDR_ADDR_MSB = 6;
  localparam int HDR_ADDR_LSB = 0;

endpackage

// File: rtl/uart_i2c_bridge.sv
// Pops {rw,addr}[,wdata] frames from the UART RX FIFO, runs one I2C transaction
// per frame and returns an ACK, read-data or NAK byte through the UART TX FIFO.
//
//   state       | meaning
//   ------------+------------------------------------------------------------
//   IDLE        | waiting for a header byte in the RX FIFO
//   GET_DATA    | write frame: waiting for the payload byte (no timeout)
//   START       | waiting for master ready, then pulse i2c_enable
//   WAIT_BUSY   | waiting for the master to drop ready
//   WAIT_DONE   | waiting for the master to raise ready again
//   RESP        | waiting for TX FIFO space, then push the response byte
module uart_i2c_bridge
  import uart_i2c_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 200000,
  parameter logic [7:0]  ACK_BYTE       = ACK_BYTE_DEF,
  parameter logic [7:0]  NAK_BYTE       = NAK_BYTE_DEF
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic       rx_empty,
  input  logic [7:0] rx_data,
  output logic       rx_pop,
  input  logic       tx_full,
  output logic       tx_push,
  output logic [7:0] tx_data,
  input  logic       i2c_ready,
  input  logic [7:0] i2c_rdata,
  output logic       i2c_enable,
  output logic [6:0] i2c_addr,
  output logic       i2c_rw,
  output logic [7:0] i2c_wdata,
  output logic       busy,
  output logic       timeout_err
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             cnt_last;

  assign cnt_last = (cnt == CNT_LAST);

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      i2c_addr  <= '0;
      i2c_rw    <= 1'b0;
      i2c_wdata <= '0;
      tx_data   <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (!rx_empty) begin
            i2c_rw   <= rx_data[HDR_RW_BIT];
            i2c_addr <= rx_data[HDR_ADDR_MSB:HDR_ADDR_LSB];
            state    <= rx_data[HDR_RW_BIT] ? ST_START : ST_GET_DATA;
          end
        end
        ST_GET_DATA: begin
          if (!rx_empty) begin
            i2c_wdata <= rx_data;
            state     <= ST_START;
          end
        end
        ST_START: begin
          if (i2c_ready) begin
            cnt   <= '0;
            state <= ST_WAIT_BUSY;
          end else if (cnt_last) begin
            tx_data <= NAK_BYTE;
            state   <= ST_RESP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_WAIT_BUSY: begin
          if (!i2c_ready) begin
            cnt   <= '0;
            state <= ST_WAIT_DONE;
          end else if (cnt_last) begin
            tx_data <= NAK_BYTE;
            state   <= ST_RESP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_WAIT_DONE: begin
          // Completion is checked first so a late ready on the terminal count still wins.
          if (i2c_ready) begin
            tx_data <= i2c_rw ? i2c_rdata : ACK_BYTE;
            state   <= ST_RESP;
          end else if (cnt_last) begin
            tx_data <= NAK_BYTE;
            state   <= ST_RESP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_RESP: begin
          if (!tx_full) begin
            cnt   <= '0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Strobes are decoded against the live FIFO/master flags so a pop or push can
  // never be issued against an empty RX or full TX FIFO.
  assign rx_pop      = !reset && !rx_empty && (state == ST_IDLE || state == ST_GET_DATA);
  assign i2c_enable  = !reset && (state == ST_START) && i2c_ready;
  assign tx_push     = !reset && (state == ST_RESP) && !tx_full;
  assign timeout_err = !reset && cnt_last &&
                       (((state == ST_START)     && !i2c_ready) ||
                        ((state == ST_WAIT_BUSY) &&  i2c_ready) ||
                        ((state == ST_WAIT_DONE) && !i2c_ready));
  assign busy        = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_i2c_bridge.sv
// Directed bench for uart_i2c_bridge: RX FIFO model, simple I2C master model and
// an event monitor; expected values are hand-computed per scenario.
module tb_uart_i2c_bridge;

  logic       clk_100MHz = 1'b0;
  logic       reset;
  logic       rx_empty;
  logic [7:0] rx_data;
  logic       rx_pop;
  logic       tx_full;
  logic       tx_push;
  logic [7:0] tx_data;
  logic       i2c_ready;
  logic [7:0] i2c_rdata;
  logic       i2c_enable;
  logic [6:0] i2c_addr;
  logic       i2c_rw;
  logic [7:0] i2c_wdata;
  logic       busy;
  logic       timeout_err;

  uart_i2c_bridge #(.TIMEOUT_CYCLES(100)) dut (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .rx_empty   (rx_empty),
    .rx_data    (rx_data),
    .rx_pop     (rx_pop),
    .tx_full    (tx_full),
    .tx_push    (tx_push),
    .tx_data    (tx_data),
    .i2c_ready  (i2c_ready),
    .i2c_rdata  (i2c_rdata),
    .i2c_enable (i2c_enable),
    .i2c_addr   (i2c_addr),
    .i2c_rw     (i2c_rw),
    .i2c_wdata  (i2c_wdata),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // cycle counter and event monitor (sampled on the falling edge)
  int cyc = 0;
  always @(posedge clk_100MHz) cyc++;

  int         n_pop, n_push, n_en, n_to, viol;
  int         pop0_cyc, en_cyc, push_cyc, to_cyc;
  logic [7:0] last_tx, en_wdata;
  logic [6:0] en_addr;
  logic       en_rw, pop_pend, prev_en, prev_push;

  initial begin
    viol = 0; pop_pend = 0; prev_en = 0; prev_push = 0;
  end

  always @(negedge clk_100MHz) begin
    pop_pend = rx_pop;
    if (rx_pop) begin
      if (n_pop == 0) pop0_cyc = cyc;
      n_pop++;
      if (rx_empty) viol++;
    end
    if (tx_push) begin
      n_push++; push_cyc = cyc; last_tx = tx_data;
      if (tx_full || prev_push) viol++;
    end
    if (i2c_enable) begin
      n_en++; en_cyc = cyc; en_addr = i2c_addr; en_rw = i2c_rw; en_wdata = i2c_wdata;
      if (prev_en) viol++;
    end
    if (timeout_err) begin
      n_to++; to_cyc = cyc;
    end
    if (32'(rx_pop) + 32'(tx_push) + 32'(i2c_enable) > 1) viol++;
    prev_en = i2c_enable;
    prev_push = tx_push;
  end

  // RX FIFO model: first-word-fall-through, popped just after the edge that consumed it
  logic [7:0] rx_q[$];

  task automatic rx_refresh();
    rx_empty = (rx_q.size() == 0);
    rx_data  = rx_empty ? 8'h00 : rx_q[0];
  endtask

  initial begin
    rx_empty = 1'b1;
    rx_data  = 8'h00;
    forever begin
      @(posedge clk_100MHz);
      #1;
      if (pop_pend && rx_q.size() > 0) void'(rx_q.pop_front());
      pop_pend = 1'b0;
      rx_refresh();
    end
  end

  task automatic send(input logic [7:0] b);
    @(posedge clk_100MHz);
    #1;
    rx_q.push_back(b);
    rx_refresh();
  endtask

  // I2C master model: after enable, ready low for m_busy cycles, then ready with m_rdata
  int         m_busy  = 40;
  logic [7:0] m_rdata = 8'h00;
  logic       m_stuck = 1'b0;

  initial begin
    i2c_ready = 1'b1;
    i2c_rdata = 8'h00;
    forever begin
      @(negedge clk_100MHz);
      if (i2c_enable && !m_stuck) begin
        @(posedge clk_100MHz);
        #1 i2c_ready = 1'b0;
        repeat (m_busy) @(posedge clk_100MHz);
        #1 i2c_rdata = m_rdata;
        i2c_ready = 1'b1;
      end
    end
  end

  task automatic clr();
    n_pop = 0; n_push = 0; n_en = 0; n_to = 0;
  endtask

  task automatic wait_push(input string tag, input int budget);
    int start;
    int k;
    start = n_push;
    k = 0;
    while (n_push == start && k < budget) begin
      @(posedge clk_100MHz);
      k++;
    end
    chk({tag, "_push_seen"}, 32'(n_push != start), 32'd1);
  endtask

  int hold_pop, hold_push, rel_cyc, k;

  initial begin
    reset = 1'b1;
    tx_full = 1'b0;
    clr();
    repeat (3) @(posedge clk_100MHz);
    @(negedge clk_100MHz);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_strobes", 32'({rx_pop, tx_push, i2c_enable, timeout_err}), 32'd0);
    chk("rst_regs", 32'({i2c_rw, i2c_addr, i2c_wdata, tx_data}), 32'd0);
    @(posedge clk_100MHz);
    #1 reset = 1'b0;

    // write frame
    clr();
    m_busy = 40;
    send(8'h2A);
    rx_q.push_back(8'h5C);
    rx_refresh();
    wait_push("wr", 500);
    chk("wr_n_en", 32'(n_en), 32'd1);
    chk("wr_addr", 32'(en_addr), 32'h2A);
    chk("wr_rw", 32'(en_rw), 32'd0);
    chk("wr_wdata", 32'(en_wdata), 32'h5C);
    chk("wr_n_pop", 32'(n_pop), 32'd2);
    chk("wr_resp", 32'(last_tx), 32'h06);
    chk("wr_pop_to_en", 32'(en_cyc - pop0_cyc), 32'd2);
    chk("wr_en_to_push", 32'(push_cyc - en_cyc), 32'd42);
    @(negedge clk_100MHz);
    chk("wr_idle", 32'(busy), 32'd0);

    // read frame
    clr();
    m_busy = 10;
    m_rdata = 8'h3C;
    send(8'hAA);
    wait_push("rd", 500);
    chk("rd_n_en", 32'(n_en), 32'd1);
    chk("rd_addr", 32'(en_addr), 32'h2A);
    chk("rd_rw", 32'(en_rw), 32'd1);
    chk("rd_n_pop", 32'(n_pop), 32'd1);
    chk("rd_resp", 32'(last_tx), 32'h3C);
    chk("rd_pop_to_en", 32'(en_cyc - pop0_cyc), 32'd1);
    chk("rd_en_to_push", 32'(push_cyc - en_cyc), 32'd12);

    // timeout: master never leaves ready
    clr();
    m_stuck = 1'b1;
    send(8'h91);
    wait_push("to", 500);
    chk("to_n_to", 32'(n_to), 32'd1);
    chk("to_en_to_err", 32'(to_cyc - en_cyc), 32'd100);
    chk("to_resp", 32'(last_tx), 32'h15);
    chk("to_en_to_push", 32'(push_cyc - en_cyc), 32'd101);
    @(negedge clk_100MHz);
    chk("to_idle", 32'(busy), 32'd0);
    m_stuck = 1'b0;

    // backpressure at RESP, second frame queued behind it
    clr();
    m_busy = 5;
    m_rdata = 8'h77;
    tx_full = 1'b1;
    send(8'hAA);
    rx_q.push_back(8'h85);
    rx_refresh();
    repeat (30) @(posedge clk_100MHz);
    hold_pop = n_pop;
    hold_push = n_push;
    repeat (50) @(posedge clk_100MHz);
    chk("bp_hold_pop", 32'(n_pop - hold_pop), 32'd0);
    chk("bp_hold_push", 32'(n_push - hold_push), 32'd0);
    chk("bp_busy", 32'(busy), 32'd1);
    #1 tx_full = 1'b0;
    rel_cyc = cyc;
    wait_push("bp", 20);
    chk("bp_push_cyc", 32'(push_cyc - rel_cyc), 32'd0);
    chk("bp_resp", 32'(last_tx), 32'h77);
    chk("bp_n_push", 32'(n_push), 32'd1);
    m_rdata = 8'h4E;
    wait_push("bp2", 500);
    chk("bp2_n_en", 32'(n_en), 32'd2);
    chk("bp2_addr", 32'({en_rw, en_addr}), 32'h85);
    chk("bp2_resp", 32'(last_tx), 32'h4E);

    // split write frame with a long gap before the payload
    clr();
    m_busy = 8;
    send(8'h10);
    repeat (300) @(posedge clk_100MHz);
    chk("split_no_en", 32'(n_en), 32'd0);
    chk("split_no_to", 32'(n_to), 32'd0);
    chk("split_n_pop", 32'(n_pop), 32'd1);
    chk("split_busy", 32'(busy), 32'd1);
    send(8'hE7);
    wait_push("split", 500);
    chk("split_frame", 32'({en_rw, en_addr, en_wdata}), 32'h10E7);
    chk("split_resp", 32'(last_tx), 32'h06);
    chk("split_no_to2", 32'(n_to), 32'd0);

    // reset while waiting for the master to finish
    clr();
    m_busy = 40;
    send(8'h22);
    rx_q.push_back(8'h33);
    rx_refresh();
    k = 0;
    while (n_en == 0 && k < 200) begin
      @(posedge clk_100MHz);
      k++;
    end
    chk("rst_mid_en", 32'(n_en), 32'd1);
    repeat (10) @(posedge clk_100MHz);
    #1 reset = 1'b1;
    @(posedge clk_100MHz);
    #1 reset = 1'b0;
    @(negedge clk_100MHz);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_regs", 32'({i2c_rw, i2c_addr, i2c_wdata, tx_data}), 32'd0);
    chk("rst_mid_strobes", 32'({rx_pop, tx_push, i2c_enable, timeout_err}), 32'd0);
    repeat (60) @(posedge clk_100MHz);
    chk("rst_mid_no_push", 32'(n_push), 32'd0);
    m_busy = 6;
    m_rdata = 8'h5A;
    send(8'hC0);
    wait_push("post_rst", 500);
    chk("post_rst_frame", 32'({en_rw, en_addr}), 32'hC0);
    chk("post_rst_resp", 32'(last_tx), 32'h5A);

    chk("protocol_viol", 32'(viol), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
